aes_mixcol_seq: RTL

AES_MIXCOL_SEQ -- requirements
Module: aes_mixcol_seq

---
 rtl/aes_mixcol_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/aes_mixcol_seq.sv
// aes_mixcol_seq: applies AES MixColumns to a 128-bit state, one 32-bit column
// per cycle. The columns are fetched through an external 4:1 word mux that
// word_sel drives.
// Optional feature: define AES_MIXCOL_INV_EN to build the InvMixColumns
// datapath. The latched inv input selects it. Without the macro the inv input
// is ignored and only the forward transform exists.
module aes_mixcol_seq (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         inv,
   output logic         in_ready,
   output logic [1:0]   word_sel,
   input  logic [31:0]  word_in,
   output logic [127:0] result,
   output logic         out_valid,
   input  logic         out_ready
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [127:0]   result_q, result_d;
   logic [31:0]    col_t;

   // Multiply by x (02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xt(input logic [7:0] b);
      xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Forward MixColumns on one column. Row 0 is in bits [31:24].
   function automatic logic [31:0] mix_fwd(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
      mix_fwd[31:24] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
      mix_fwd[23:16] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
      mix_fwd[15:8]  = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
      mix_fwd[7:0]   = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
   endfunction

`ifdef AES_MIXCOL_INV_EN
   logic inv_q, inv_d;

   // Inverse MixColumns on one column. The coefficients 0e/0b/0d/09 are built
   // from repeated doublings.
   function automatic logic [31:0] mix_inv(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4], mb [4], md [4], me [4];
      logic [7:0] x2, x4, x8;
      a[0] = c[31:24]; a[1] = c[23:16]; a[2] = c[15:8]; a[3] = c[7:0];
      for (int i = 0; i < 4; i++) begin
         x2 = xt(a[i]);
         x4 = xt(x2);
         x8 = xt(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      mix_inv[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      mix_inv[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      mix_inv[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      mix_inv[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
   endfunction

   // The column transform is chosen by the direction latched at accept time.
   always_comb begin
      col_t = inv_q ? mix_inv(word_in) : mix_fwd(word_in);
   end
`else
   logic unused_inv;
   assign unused_inv = inv;

   // Forward-only build: every column goes through MixColumns.
   always_comb begin
      col_t = mix_fwd(word_in);
   end
`endif

   // Next-state logic. The column counter walks 0..3 in RUN with no stalls,
   // and each transformed column lands straight in the result register.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      result_d = result_q;
`ifdef AES_MIXCOL_INV_EN
      inv_d    = inv_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = 2'd0;
`ifdef AES_MIXCOL_INV_EN
               inv_d   = inv;
`endif
            end
         end
         RUN: begin
            case (cnt_q)
               2'd0:    result_d[127:96] = col_t;
               2'd1:    result_d[95:64]  = col_t;
               2'd2:    result_d[63:32]  = col_t;
               default: result_d[31:0]   = col_t;
            endcase
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register. Reset overrides everything and drops any partial block.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         result_q <= 128'h0;
`ifdef AES_MIXCOL_INV_EN
         inv_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
`ifdef AES_MIXCOL_INV_EN
         inv_q    <= inv_d;
`endif
      end
   end

   // Outputs decode directly from registered state. word_sel rests at column 0.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      word_sel  = (state_q == RUN) ? cnt_q : 2'b00;
      result    = result_q;
   end

endmodule
